// File: rtl/ram_write_scheduler_pkg.sv
// Shared definitions for the RAM write scheduler: FSM state type, mux
// select codes, requester indices and small decode helpers.
package ram_write_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_BURST,
    ST_DONE
  } state_t;

  // Requester indices (bit positions in Req/Valid/Grant/Done)
  localparam logic [1:0] IDX_DEC   = 2'd0;
  localparam logic [1:0] IDX_FILE  = 2'd1;
  localparam logic [1:0] IDX_LAYER = 2'd2;
  localparam logic [1:0] IDX_CNN   = 2'd3;

  // Mux select codes {Load, Image, Layer}
  localparam logic [2:0] SEL_NONE  = 3'b000;
  localparam logic [2:0] SEL_DEC   = 3'b100;
  localparam logic [2:0] SEL_FILE  = 3'b110;
  localparam logic [2:0] SEL_LAYER = 3'b001;
  localparam logic [2:0] SEL_CNN   = 3'b011;

  function automatic logic [2:0] sel_code(input logic [1:0] idx);
    case (idx)
      IDX_DEC:   sel_code = SEL_DEC;
      IDX_FILE:  sel_code = SEL_FILE;
      IDX_LAYER: sel_code = SEL_LAYER;
      default:   sel_code = SEL_CNN;
    endcase
  endfunction

  function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
    case (oh)
      4'b0010: onehot_to_idx = IDX_FILE;
      4'b0100: onehot_to_idx = IDX_LAYER;
      4'b1000: onehot_to_idx = IDX_CNN;
      default: onehot_to_idx = IDX_DEC;
    endcase
  endfunction

endpackage

// File: rtl/ram_write_scheduler_rr_arbiter4.sv
// rr_arbiter4: combinational 4-way round-robin picker.
// Ports:
//   req   - request vector, bit i = requester i
//   last  - index of the previous owner; search begins at last+1
//   grant - one-hot winner, all zero when req is zero
module rr_arbiter4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [3:0] grant
);

  always_comb begin
    logic [1:0] idx;
    logic       found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    // k runs 1..4 so the previous owner is tried last
    for (int unsigned k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_write_scheduler.sv
// ram_write_scheduler: grants fixed-length write bursts into a shared RAM to
// four requesters, each owning a circular region addressed by a persistent
// write pointer.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   Req[3:0]              - burst requests (0 dec, 1 file, 2 layer, 3 CNN)
//   Valid[3:0]            - per-requester data-valid strobes
//   PtrClr                - return all pointers to region bases (IDLE only)
//   Grant[3:0]            - one-hot current owner
//   Load, Image, Layer    - registered mux select code
//   WriteEn, Addr         - combinational RAM write enable / address
//   Done[3:0]             - one-cycle end-of-burst pulse to the owner
//   Busy                  - FSM not idle
module ram_write_scheduler
  import ram_write_scheduler_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned BURST_LEN   = 64,
  parameter int unsigned REGION_SIZE = 4096,
  parameter int unsigned BASE_DEC    = 0,
  parameter int unsigned BASE_FILE   = 4096,
  parameter int unsigned BASE_LAYER  = 8192,
  parameter int unsigned BASE_CNN    = 12288
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        Req,
  input  logic [3:0]        Valid,
  input  logic              PtrClr,
  output logic [3:0]        Grant,
  output logic              Load,
  output logic              Image,
  output logic              Layer,
  output logic              WriteEn,
  output logic [ADDR_W-1:0] Addr,
  output logic [3:0]        Done,
  output logic              Busy
);

  localparam int unsigned PTR_W  = (REGION_SIZE > 1) ? $clog2(REGION_SIZE) : 1;
  localparam int unsigned BEAT_W = $clog2(BURST_LEN + 1);

  state_t              state;
  logic [1:0]          owner;       // current owner, doubles as round-robin last owner
  logic [3:0]          grant_q;
  logic [3:0]          done_q;
  logic [2:0]          sel_q;
  logic [PTR_W-1:0]    ptr [4];
  logic [BEAT_W-1:0]   beat;
  logic [3:0]          arb_grant;
  logic [1:0]          arb_idx;
  logic                write;
  logic [ADDR_W-1:0]   base;

  rr_arbiter4 u_arb (
    .req   (Req),
    .last  (owner),
    .grant (arb_grant)
  );

  assign arb_idx = onehot_to_idx(arb_grant);
  assign write   = (state == ST_BURST) && Valid[owner];

  always_comb begin
    base = ADDR_W'(BASE_DEC);
    case (owner)
      IDX_FILE:  base = ADDR_W'(BASE_FILE);
      IDX_LAYER: base = ADDR_W'(BASE_LAYER);
      IDX_CNN:   base = ADDR_W'(BASE_CNN);
      default:   base = ADDR_W'(BASE_DEC);
    endcase
  end

  assign Addr    = base + ADDR_W'(ptr[owner]);
  assign WriteEn = write;
  assign Grant   = grant_q;
  assign Done    = done_q;
  assign {Load, Image, Layer} = sel_q;
  assign Busy    = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      owner   <= IDX_CNN;
      grant_q <= '0;
      done_q  <= '0;
      sel_q   <= SEL_NONE;
      beat    <= '0;
      for (int unsigned i = 0; i < 4; i++) ptr[i] <= '0;
    end else begin
      done_q <= '0;
      case (state)
        ST_IDLE: begin
          if (PtrClr) begin
            for (int unsigned i = 0; i < 4; i++) ptr[i] <= '0;
          end
          if (|Req) begin
            owner   <= arb_idx;
            grant_q <= arb_grant;
            sel_q   <= sel_code(arb_idx);
            beat    <= '0;
            state   <= ST_SETUP;
          end
        end
        ST_SETUP: state <= ST_BURST;
        ST_BURST: begin
          if (write) begin
            // Region size is a power of two, so the pointer wraps naturally
            ptr[owner] <= ptr[owner] + PTR_W'(1);
            if (beat == BEAT_W'(BURST_LEN - 1)) begin
              beat    <= '0;
              done_q  <= grant_q;
              grant_q <= '0;
              sel_q   <= SEL_NONE;
              state   <= ST_DONE;
            end else begin
              beat <= beat + BEAT_W'(1);
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_write_scheduler.sv
module tb_ram_write_scheduler;

  localparam int BL = 64;
  localparam int RS = 128;

  logic        clk;
  logic        rst_n;
  logic [3:0]  Req, Valid, Grant, Done;
  logic        PtrClr, Load, Image, Layer, WriteEn, Busy;
  logic [15:0] Addr;

  int vectors;
  int miscompares;

  ram_write_scheduler #(
    .ADDR_W(16), .BURST_LEN(BL), .REGION_SIZE(RS),
    .BASE_DEC(0), .BASE_FILE(4096), .BASE_LAYER(8192), .BASE_CNN(12288)
  ) dut (
    .clk(clk), .rst_n(rst_n), .Req(Req), .Valid(Valid), .PtrClr(PtrClr),
    .Grant(Grant), .Load(Load), .Image(Image), .Layer(Layer),
    .WriteEn(WriteEn), .Addr(Addr), .Done(Done), .Busy(Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int base_of(input int c);
    return c * 4096;
  endfunction

  function automatic logic [2:0] code_of(input int c);
    case (c)
      0: return 3'b100;
      1: return 3'b110;
      2: return 3'b001;
      default: return 3'b011;
    endcase
  endfunction

  // ---------------- behavioural model + per-cycle compare ----------------
  int m_owner;      // -1 when no burst is running
  int m_last;
  bit m_setup;
  bit m_done;
  int m_left;
  int m_ptr [4];

  task automatic model_reset();
    m_owner = -1; m_last = 3; m_setup = 0; m_done = 0; m_left = 0;
    for (int i = 0; i < 4; i++) m_ptr[i] = 0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_grant", {28'd0, Grant}, 0);
        chk("rst_sel", {29'd0, Load, Image, Layer}, 0);
        chk("rst_done", {28'd0, Done}, 0);
        chk("rst_busy", {31'd0, Busy}, 0);
        chk("rst_we", {31'd0, WriteEn}, 0);
        model_reset();
      end else begin
        bit active, we;
        int o;
        o = m_owner;
        active = (o >= 0) && !m_done;
        we = active && !m_setup && Valid[o];
        chk("busy", {31'd0, Busy}, {31'd0, (o >= 0)});
        chk("grant", {28'd0, Grant}, active ? (32'd1 << o) : 0);
        chk("sel", {29'd0, Load, Image, Layer}, active ? {29'd0, code_of(o)} : 0);
        chk("done", {28'd0, Done}, m_done ? (32'd1 << o) : 0);
        chk("we", {31'd0, WriteEn}, {31'd0, we});
        if (we) chk("addr", {16'd0, Addr}, base_of(o) + m_ptr[o]);
        // advance to the next cycle
        if (o < 0) begin
          if (PtrClr) for (int i = 0; i < 4; i++) m_ptr[i] = 0;
          if (Req != 0) begin
            for (int k = 1; k <= 4; k++) begin
              if (m_owner < 0 && Req[(m_last + k) % 4]) m_owner = (m_last + k) % 4;
            end
            m_last = m_owner; m_setup = 1; m_left = BL;
          end
        end else if (m_done) begin
          m_owner = -1; m_done = 0;
        end else if (m_setup) begin
          m_setup = 0;
        end else if (we) begin
          m_ptr[o] = (m_ptr[o] + 1) % RS;
          m_left--;
          if (m_left == 0) m_done = 1;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; Req = '0; Valid = '0; PtrClr = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // One burst for requester rq. toggle: Valid[owner] alternates 0,1,... from
  // the first burst cycle. Other Valid bits carry random noise.
  task automatic run_burst(input logic [3:0] rq, input logic clr, input bit toggle,
                           output logic [15:0] first_a, output logic [15:0] last_a,
                           output int nwr, output int ncyc);
    int  idx;
    bit  seen, ph, got_done;
    logic [3:0] v;
    idx = 0;
    for (int i = 0; i < 4; i++) if (rq[i]) idx = i;
    first_a = '0; last_a = '0;
    nwr = 0; ncyc = 0; seen = 0; ph = 0; got_done = 0;
    Req = rq; PtrClr = clr;
    v = 4'($urandom); v[idx] = !toggle; Valid = v;
    for (int t = 0; t < 1000 && !got_done; t++) begin
      @(negedge clk);
      if (WriteEn) begin
        if (nwr == 0) first_a = Addr;
        last_a = Addr;
        nwr++;
      end
      if (Grant != 0) begin
        if (!seen) begin seen = 1; ph = 0; end
        else ncyc++;
      end
      if (Done != 0) got_done = 1;
      tick();
      PtrClr = 1'b0;
      if (seen) Req = '0;
      v = 4'($urandom);
      if (toggle) begin
        v[idx] = seen ? ph : 1'b0;
        if (seen) ph = !ph;
      end else begin
        v[idx] = 1'b1;
      end
      Valid = v;
    end
    if (!got_done) chk("burst_timeout", 0, 1);
    Req = '0; Valid = '0;
  endtask

  logic [15:0] fa, la;
  int nw, nc;
  logic [3:0] prev_g;
  int ng;
  logic [3:0] exp_g [5];
  logic [2:0] exp_s [5];

  initial begin
    vectors = 0; miscompares = 0;
    rst_n = 1'b0; Req = '0; Valid = '0; PtrClr = 1'b0;

    // Single decompressor burst: select from cycle 1, writes 0..63 on 2..65, Done on 66
    do_reset();
    Req = 4'b0001; Valid = 4'b0001;
    for (int k = 0; k <= 66; k++) begin
      @(negedge clk);
      if (k == 0) chk("c0_sel", {29'd0, Load, Image, Layer}, 0);
      if (k == 1) begin
        chk("c1_sel", {29'd0, Load, Image, Layer}, 3'b100);
        chk("c1_grant", {28'd0, Grant}, 4'b0001);
        chk("c1_we", {31'd0, WriteEn}, 0);
      end
      if (k >= 2 && k <= 65) begin
        chk("dec_we", {31'd0, WriteEn}, 1);
        chk("dec_addr", {16'd0, Addr}, k - 2);
      end
      if (k == 65) chk("c65_done", {28'd0, Done}, 0);
      if (k == 66) begin
        chk("c66_done", {28'd0, Done}, 4'b0001);
        chk("c66_we", {31'd0, WriteEn}, 0);
      end
      tick();
      if (k == 1) Req = '0;
    end
    Valid = '0;

    // Round-robin with all requesting
    do_reset();
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_s = '{3'b100, 3'b110, 3'b001, 3'b011, 3'b100};
    Req = 4'b1111; Valid = 4'b1111;
    prev_g = '0; ng = 0;
    for (int t = 0; t < 1000 && ng < 5; t++) begin
      @(negedge clk);
      if (prev_g == 0 && Grant != 0) begin
        chk("rr_grant", {28'd0, Grant}, {28'd0, exp_g[ng]});
        chk("rr_sel", {29'd0, Load, Image, Layer}, {29'd0, exp_s[ng]});
        ng++;
      end
      prev_g = Grant;
      tick();
    end
    chk("rr_count", ng, 5);
    Req = '0; Valid = '0;

    // File region wraps after two bursts (REGION_SIZE=128)
    do_reset();
    run_burst(4'b0010, 1'b0, 1'b0, fa, la, nw, nc);
    chk("file1_first", {16'd0, fa}, 4096); chk("file1_last", {16'd0, la}, 4159);
    chk("file1_n", nw, 64);
    run_burst(4'b0010, 1'b0, 1'b0, fa, la, nw, nc);
    chk("file2_first", {16'd0, fa}, 4160); chk("file2_last", {16'd0, la}, 4223);
    run_burst(4'b0010, 1'b0, 1'b0, fa, la, nw, nc);
    chk("file3_first", {16'd0, fa}, 4096); chk("file3_last", {16'd0, la}, 4159);

    // Layer burst with Valid toggling and noise on other strobes
    do_reset();
    run_burst(4'b0100, 1'b0, 1'b1, fa, la, nw, nc);
    chk("tog_cycles", nc, 128);
    chk("tog_writes", nw, 64);
    chk("tog_first", {16'd0, fa}, 8192); chk("tog_last", {16'd0, la}, 8255);

    // Reset at beat 30 of a CNN burst
    do_reset();
    Req = 4'b1000; Valid = 4'b1000;
    nw = 0;
    for (int t = 0; t < 200 && nw < 30; t++) begin
      @(negedge clk);
      if (WriteEn) nw++;
      if (Busy) Req = '0;
      tick();
    end
    chk("cnn_beats", nw, 30);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_grant", {28'd0, Grant}, 0);
    chk("mid_rst_sel", {29'd0, Load, Image, Layer}, 0);
    chk("mid_rst_busy", {31'd0, Busy}, 0);
    chk("mid_rst_we", {31'd0, WriteEn}, 0);
    chk("mid_rst_done", {28'd0, Done}, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_hold_done", {28'd0, Done}, 0);
      tick();
    end
    Valid = '0;
    rst_n = 1'b1;
    run_burst(4'b1000, 1'b0, 1'b0, fa, la, nw, nc);
    chk("cnn_after_rst", {16'd0, fa}, 12288);

    // PtrClr with Req in the same idle cycle
    do_reset();
    run_burst(4'b0100, 1'b0, 1'b0, fa, la, nw, nc);
    chk("lay1_first", {16'd0, fa}, 8192);
    run_burst(4'b0100, 1'b0, 1'b0, fa, la, nw, nc);
    chk("lay2_first", {16'd0, fa}, 8256);
    run_burst(4'b0100, 1'b1, 1'b0, fa, la, nw, nc);
    chk("lay_clr_first", {16'd0, fa}, 8192);

    // Random traffic checked by the model each cycle
    do_reset();
    for (int t = 0; t < 3000; t++) begin
      Req = 4'($urandom);
      Valid = 4'($urandom) | 4'($urandom);
      PtrClr = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 999) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      tick();
    end
    rst_n = 1'b1; Req = '0; Valid = '0; PtrClr = 1'b0;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
